// File: rtl/ram_copy_engine.sv
`default_nettype none
// ============================================================================
// Module      : ram_copy_engine
// Description : Copies len words inside a dual-port RAM, reading on port A
//               and writing on port B at one word per cycle. The copy is a
//               three-phase pipeline: PRIME issues the first read, STREAM
//               writes word k-1 while reading word k, and FLUSH writes the
//               final word. Addresses wrap modulo 2**ADDR_W.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : ADDR_W - RAM address width (depth 2**ADDR_W words)
//               DATA_W - RAM word width
// Ports       : clk, rst_n             - clock, async active-low reset
//               start, abort           - copy request / cancel
//               src_addr, dst_addr,len - copy operands, captured on start
//               busy, done, err        - status (done/err are 1-cycle pulses)
//               we_a, addr_a, data_in_a, data_out_a - RAM port A (read only)
//               we_b, addr_b, data_in_b, data_out_b - RAM port B (write only)
//               csum                   - XOR of the words written by the
//                                        current copy (optional)
// Options     : define RAM_COPY_CHECKSUM_EN to add the csum output.
// ============================================================================
module ram_copy_engine #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              we_a,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_in_a,
  input  logic [DATA_W-1:0] data_out_a,
  output logic              we_b,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_in_b,
  input  logic [DATA_W-1:0] data_out_b
`ifdef RAM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRIME  = 2'd1,
    S_STREAM = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  // Largest legal word count: the whole RAM.
  localparam logic [ADDR_W:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_len;
  // Read offset: 0 in PRIME, k in STREAM word k, len in FLUSH.
  logic [ADDR_W:0]   r_k;
  logic              r_done;
  logic              r_err;

  logic              w_len_ok;
  logic              w_accept;
  logic              w_done_next;
  logic              w_err_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;

  // Port B read data is never consumed by this engine.
  logic              w_unused;
  assign w_unused = ^data_out_b;

  assign w_len_ok  = (len != '0) && (len <= c_max_len);
  // Writes lag reads by one word because port A has a registered output.
  assign w_rd_addr = r_src + r_k[ADDR_W-1:0];
  assign w_wr_addr = r_dst + r_k[ADDR_W-1:0] - ADDR_W'(1);

  assign we_a      = 1'b0;
  assign data_in_a = '0;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (w_accept) begin
        r_src <= src_addr;
        r_dst <= dst_addr;
        r_len <= len;
        r_k   <= '0;
      end else if ((r_state == S_PRIME) || (r_state == S_STREAM)) begin
        r_k <= r_k + (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    busy         = 1'b0;
    addr_a       = '0;
    we_b         = 1'b0;
    addr_b       = '0;
    data_in_b    = '0;
    case (r_state)
      S_IDLE: begin
        // abort alongside start turns the request into a rejection.
        if (start) begin
          if (abort || !w_len_ok) begin
            w_err_next = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        busy   = 1'b1;
        addr_a = r_src;
        if (abort) begin
          w_next_state = S_IDLE;
          w_err_next   = 1'b1;
        end else if (r_len == (ADDR_W+1)'(1)) begin
          w_next_state = S_FLUSH;
        end else begin
          w_next_state = S_STREAM;
        end
      end
      S_STREAM: begin
        busy      = 1'b1;
        addr_a    = w_rd_addr;
        we_b      = 1'b1;
        addr_b    = w_wr_addr;
        data_in_b = data_out_a;
        if (abort) begin
          w_next_state = S_IDLE;
          w_err_next   = 1'b1;
        end else if (r_k == (r_len - (ADDR_W+1)'(1))) begin
          w_next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy      = 1'b1;
        we_b      = 1'b1;
        addr_b    = w_wr_addr;
        data_in_b = data_out_a;
        w_next_state = S_IDLE;
        // The final write still lands this cycle; abort only swaps done for err.
        if (abort) begin
          w_err_next = 1'b1;
        end else begin
          w_done_next = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

`ifdef RAM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (we_b) begin
      r_csum <= r_csum ^ data_in_b;
    end
  end

  assign csum = r_csum;
`endif

endmodule
`default_nettype wire
